// File: rtl/serial_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared definitions for the serializer / deserializer pair:
//                FSM state encoding, default frame width and the helper
//                that sizes the bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

   // Default number of data bits per frame.
   localparam int DATA_W_DEFAULT = 8;

   // Frame FSM states. PARITY is only reachable when parity is enabled.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2,
      ST_DONE   = 2'd3
   } serial_state_e;

   // The counter carries one spare bit so the last index is reached
   // without ever wrapping.
   function automatic int cnt_width(input int data_w);
      return $clog2(data_w) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serializer
//  Description : Parallel-to-serial frame transmitter, MSB first, with a
//                DONE/ack handshake before the next word is accepted.
//                Optional build macro SERIALIZER_PARITY_EN appends one even
//                parity bit after the data bits.
//  Ports       : clk_100khz  in   block clock, rising edge
//                reset       in   asynchronous, active-high reset
//                data_in     in   [DATA_W-1:0] word to transmit
//                load_in     in   word valid, taken only while idle
//                ack_in      in   consumer ack, taken only in DONE
//                data_out    out  serial bit (valid while write_out=1)
//                write_out   out  serial bit strobe
//                frame_done  out  frame finished, waiting for ack_in
//                status_out  out  1 = idle/available, 0 = busy
//  Revision    : 1.0 - initial release
// ============================================================================
module serializer
   import serial_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk_100khz,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load_in,
   input  logic              ack_in,
   output logic              data_out,
   output logic              write_out,
   output logic              frame_done,
   output logic              status_out
);

   localparam int              CNT_W    = cnt_width(DATA_W);
   localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(DATA_W - 1);

   localparam logic [1:0] C_IDLE   = ST_IDLE;
   localparam logic [1:0] C_SHIFT  = ST_SHIFT;
   localparam logic [1:0] C_DONE   = ST_DONE;
`ifdef SERIALIZER_PARITY_EN
   localparam logic [1:0] C_PARITY = ST_PARITY;
   // SHIFT hands over to the parity cycle before the frame completes.
   localparam logic [1:0] C_AFTER_SHIFT = C_PARITY;
`else
   localparam logic [1:0] C_AFTER_SHIFT = C_DONE;
`endif

   logic [1:0]        r_state;
   logic [DATA_W-1:0] r_shift;
   logic [CNT_W-1:0]  r_cnt;
`ifdef SERIALIZER_PARITY_EN
   logic              r_parity;
`endif

   always_ff @(posedge clk_100khz or posedge reset) begin
      if (reset) begin
         r_state    <= C_IDLE;
         r_shift    <= '0;
         r_cnt      <= '0;
`ifdef SERIALIZER_PARITY_EN
         r_parity   <= 1'b0;
`endif
         data_out   <= 1'b0;
         write_out  <= 1'b0;
         frame_done <= 1'b0;
         status_out <= 1'b1;
      end else begin
         case (r_state)
            C_IDLE: begin
               data_out   <= 1'b0;
               write_out  <= 1'b0;
               frame_done <= 1'b0;
               if (load_in) begin
                  r_shift    <= data_in;
                  r_cnt      <= '0;
`ifdef SERIALIZER_PARITY_EN
                  // Parity is taken from the captured word so later changes
                  // on data_in cannot disturb it.
                  r_parity   <= ^data_in;
`endif
                  r_state    <= C_SHIFT;
                  status_out <= 1'b0;
               end else begin
                  status_out <= 1'b1;
               end
            end

            C_SHIFT: begin
               write_out  <= 1'b1;
               data_out   <= r_shift[DATA_W-1];
               r_shift    <= {r_shift[DATA_W-2:0], 1'b0};
               frame_done <= 1'b0;
               status_out <= 1'b0;
               // Leave on the last index; the counter is never advanced past it.
               if (r_cnt == C_LAST) begin
                  r_state <= C_AFTER_SHIFT;
               end else begin
                  r_cnt   <= r_cnt + CNT_W'(1);
               end
            end

`ifdef SERIALIZER_PARITY_EN
            C_PARITY: begin
               write_out  <= 1'b1;
               data_out   <= r_parity;
               frame_done <= 1'b0;
               status_out <= 1'b0;
               r_state    <= C_DONE;
            end
`endif

            C_DONE: begin
               write_out <= 1'b0;
               data_out  <= 1'b0;
               // load_in is deliberately not looked at here: a load that
               // coincides with ack is dropped, not queued.
               if (ack_in) begin
                  r_state    <= C_IDLE;
                  frame_done <= 1'b0;
                  status_out <= 1'b1;
               end else begin
                  frame_done <= 1'b1;
                  status_out <= 1'b0;
               end
            end

            default: begin
               r_state    <= C_IDLE;
               data_out   <= 1'b0;
               write_out  <= 1'b0;
               frame_done <= 1'b0;
               status_out <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
